// File: rtl/msg_pkg.sv
// Shared message framing definitions.
// Used by the inbound deserializer and the outbound serializer.
package msg_pkg;

  localparam int BEAT_W     = 32;
  localparam int PORTAL_LSB = 16;
  localparam int LEN_MSB    = 15;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } msg_state_t;

  function automatic logic [15:0] hdr_len(
    input logic [BEAT_W-1:0] hdr
  );
    return hdr[LEN_MSB:0];
  endfunction

  function automatic logic [15:0] hdr_portal(
    input logic [BEAT_W-1:0] hdr
  );
    return hdr[BEAT_W-1:PORTAL_LSB];
  endfunction

endpackage

// File: rtl/msg_sink_deser.sv
// Inbound message deserializer: collects a header plus L
// 32-bit payload beats into one wide register for downstream.
module msg_sink_deser
  import msg_pkg::*;
#(
  parameter int MAX_IN_WIDTH = 1024
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    beat_valid,
  input  logic [BEAT_W-1:0]       beat_data,
  input  logic                    beat_last,
  output logic                    beat_ready,
  output logic                    out_valid,
  output logic [MAX_IN_WIDTH-1:0] out_data,
  input  logic                    out_ready,
  output logic                    err_len
);

  localparam int CAP = MAX_IN_WIDTH / BEAT_W - 1;
  localparam int PW  = $clog2(CAP + 1);

  if ((MAX_IN_WIDTH % BEAT_W) != 0 || MAX_IN_WIDTH < 64)
  begin : g_bad_width
    $error("MAX_IN_WIDTH must be a multiple of 32, >= 64");
  end

  msg_state_t      state;
  logic [15:0]     remaining;
  logic [PW-1:0]   wptr;
  logic            acc;
  logic [15:0]     len;
  logic            over;
  logic            slot_ok;
  logic            cnt_end;

  assign acc     = beat_valid && beat_ready;
  assign len     = hdr_len(beat_data);
  assign over    = 32'(len) > CAP;
  assign slot_ok = 32'(wptr) < CAP;
  assign cnt_end = remaining == 16'd1;

  // Framing FSM plus the message register with per-beat write enables.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      remaining  <= '0;
      wptr       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      err_len    <= 1'b0;
      beat_ready <= 1'b1;
    end else begin
      err_len <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            out_data  <= {{(MAX_IN_WIDTH-BEAT_W){1'b0}},
                          beat_data};
            wptr      <= '0;
            remaining <= len;
            err_len   <= over ||
                         (beat_last != (len == 16'd0));
            if (len == 16'd0 || beat_last) begin
              state      <= HOLD;
              remaining  <= '0;
              out_valid  <= 1'b1;
              beat_ready <= 1'b0;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (acc) begin
            if (slot_ok) wptr <= wptr + PW'(1);
            remaining <= beat_last ? 16'd0
                                   : remaining - 16'd1;
            if (beat_last || cnt_end) begin
              state      <= HOLD;
              out_valid  <= 1'b1;
              beat_ready <= 1'b0;
              err_len    <= beat_last != cnt_end;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            beat_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          out_valid  <= 1'b0;
          beat_ready <= 1'b1;
        end
      endcase
      for (int i = 0; i < CAP; i++) begin
        if (state == COLLECT && acc &&
            wptr == PW'(i)) begin
          out_data[BEAT_W*(i+1) +: BEAT_W] <= beat_data;
        end
      end
    end
  end

endmodule

// File: doc/msg_sink_deser.md
MSG_SINK_DESER -- requirements
Module: msg_sink_deser

Interface
REQ-001 SHALL have parameter MAX_IN_WIDTH, default 1024, meaning the assembled message width in bits; it SHALL be a multiple of 32 and at least 64.
REQ-002 SHALL have port CLK, input, 1 bit: clock; all logic is on the rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port beat_valid, input, 1 bit: an inbound 32-bit beat is present.
REQ-005 SHALL have port beat_data, input, 32 bits: beat payload.
REQ-006 SHALL have port beat_last, input, 1 bit: the sender marks this beat as the final beat.
REQ-007 SHALL have port beat_ready, output, 1 bit: a beat is accepted when beat_valid && beat_ready.
REQ-008 SHALL have port out_valid, output, 1 bit: the assembled message is available.
REQ-009 SHALL have port out_data, output, MAX_IN_WIDTH bits: the assembled message.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes the message when out_valid && out_ready.
REQ-011 SHALL have port err_len, output, 1 bit: single-cycle pulse on a framing error.

Function
REQ-012 SHALL treat the first accepted beat of each message as the header: [31:16] = portal id, [15:0] = L, the number of payload beats that follow.
REQ-013 SHALL store the header at out_data[31:0] and payload beat k (k = 0..L-1) at out_data[32*(k+1)+31 : 32*(k+1)].
REQ-014 SHALL clear all out_data bits above the last written beat when a header is accepted.
REQ-015 SHALL implement three states:
- IDLE: waiting for a header.
- COLLECT: remaining-count > 0.
- HOLD: message presented to downstream.
REQ-016 SHALL drive beat_ready = 1 in IDLE and COLLECT, and 0 in HOLD.
REQ-017 SHALL, in IDLE on header accept, load remaining = L and go to COLLECT if L > 0, or to HOLD if L = 0.
REQ-018 SHALL, in COLLECT on each accepted beat, decrement remaining and go to HOLD when remaining reaches 0.
REQ-019 SHALL assert out_valid exactly in HOLD; out_valid therefore rises on the cycle after the final beat is accepted (latency 1).
REQ-020 SHALL, in HOLD, hold out_data stable until the cycle in which out_valid && out_ready, and enter IDLE on the next cycle.
REQ-021 SHALL not accept a header in the same cycle as the HOLD handshake; minimum cost is L+2 cycles per message.
REQ-022 SHALL, if beat_last is accepted before remaining reaches 0, end the message at that beat, enter HOLD and pulse err_len.
REQ-023 SHALL, if the final counted beat arrives without beat_last, deliver the message normally and pulse err_len.
REQ-024 SHALL compute the capacity C = MAX_IN_WIDTH/32 - 1 payload beats.
REQ-025 SHALL, when L > C, accept and discard beats beyond C (no write, counting continues) and pulse err_len once on the header.
REQ-026 SHALL use a 16-bit remaining counter that never wraps below 0.
REQ-027 SHALL index payload writes with a write pointer of width clog2(C+1).
REQ-028 SHALL ignore beat_data and beat_last whenever no beat is accepted.

Reset
REQ-029 SHALL, while RST_N = 0 at a clock edge, set state = IDLE, remaining = 0, write pointer = 0, out_data = 0, out_valid = 0, err_len = 0 and beat_ready = 1 (beat_ready is 1 immediately after reset).
REQ-030 SHALL, on reset mid-message (COLLECT or HOLD), discard the partial or held message without ever asserting out_valid for it.

Structure
REQ-031 SHALL place BEAT_W = 32, the header field positions (PORTAL_LSB = 16, LEN_MSB = 15) and the state enum (IDLE, COLLECT, HOLD) in a shared package, msg_pkg, shared with the outbound serializer.
REQ-032 SHALL be a single module with no sub-module; the datapath is one register with beat-indexed write enables.

Verification
REQ-033 SHALL verify: header 0x0005_0002, then beats 0xAAAA_AAAA and 0xBBBB_BBBB (last on the second) -> out_valid on the cycle after the last beat; out_data[95:0] = BBBB_BBBB_AAAA_AAAA_0005_0002; upper bits 0; err_len = 0.
REQ-034 SHALL verify: header 0x0007_0000 with last -> HOLD next cycle; out_data = 0x0007_0000; out_ready held 0 for 5 cycles -> out_valid and out_data stable and beat_ready = 0 throughout.
REQ-035 SHALL verify: header L = 3, last asserted on payload beat 1 -> message ends after 2 payload beats; err_len pulses for 1 cycle; out_valid asserted.
REQ-036 SHALL verify: MAX_IN_WIDTH = 128, header L = 5 -> all 6 beats accepted; only payload beats 0..2 stored; err_len pulses once on the header.
REQ-037 SHALL verify: RST_N driven low after 1 of 3 payload beats, then released, then a new header L = 1 -> only the new message is presented; no stale bits in out_data.
REQ-038 SHALL verify: back-to-back messages with out_ready tied 1 -> beat_ready is low for exactly one cycle between messages; both messages delivered intact.
